// File: rtl/imem_fetch_unit.sv
// imem_fetch_unit: big-endian instruction store with a post-reset clear, a load port and a valid/ready fetch port.
// Define IMEM_LD_BYPASS_EN to forward a same-cycle load into a fetch of the same word.
module imem_fetch_unit #(
    parameter int WORD_LEN    = 32,
    parameter int CELL_W      = 8,
    parameter int DEPTH_BYTES = 1024,
    parameter int ADDR_W      = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ld_en,
    input  logic [ADDR_W-1:0]   ld_addr,
    input  logic [WORD_LEN-1:0] ld_data,
    output logic                init_done,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic                flush,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [WORD_LEN-1:0] rsp_instr,
    output logic [1:0]          rsp_fault
);
    localparam int CELLS = WORD_LEN / CELL_W;
    localparam int W     = DEPTH_BYTES / CELLS;
    localparam int LSB   = $clog2(CELLS);
    localparam int IDX_W = (W > 1) ? $clog2(W) : 1;

    typedef enum logic {CLEAR, RUN} state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    clr_idx_q, clr_idx_d;
    logic                init_done_q, init_done_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [WORD_LEN-1:0] rsp_instr_q, rsp_instr_d;
    logic [1:0]          rsp_fault_q, rsp_fault_d;
    logic [WORD_LEN-1:0] mem [W];
    logic                ld_ok, req_mis, req_oor, accept, mem_we;
    logic [IDX_W-1:0]    ld_idx, req_idx, mem_widx;
    logic [WORD_LEN-1:0] mem_wdata, rd_word;

    assign ld_idx    = ld_addr[LSB +: IDX_W];
    assign req_idx   = req_addr[LSB +: IDX_W];
    assign ld_ok     = state_q == RUN && ld_en && (ld_addr & ADDR_W'(CELLS - 1)) == '0
                       && ld_addr < ADDR_W'(DEPTH_BYTES);
    assign req_mis   = (req_addr & ADDR_W'(CELLS - 1)) != '0;
    assign req_oor   = req_addr >= ADDR_W'(DEPTH_BYTES);
    assign req_ready = state_q == RUN && !flush && (!rsp_valid_q || rsp_ready);
    assign accept    = req_valid && req_ready;

    // Faulting fetches never touch the array and return zero.
`ifdef IMEM_LD_BYPASS_EN
    assign rd_word = (req_mis || req_oor) ? '0 : (ld_ok && ld_idx == req_idx) ? ld_data : mem[req_idx];
`else
    assign rd_word = (req_mis || req_oor) ? '0 : mem[req_idx];
`endif

    always_comb begin
        state_d     = state_q;
        clr_idx_d   = clr_idx_q;
        init_done_d = init_done_q;
        rsp_instr_d = rsp_instr_q;
        rsp_fault_d = rsp_fault_q;
        mem_we      = ld_ok;
        mem_widx    = ld_idx;
        mem_wdata   = ld_data;
        if (state_q == CLEAR) begin
            mem_we    = 1'b1;
            mem_widx  = clr_idx_q;
            mem_wdata = '0;
            clr_idx_d = clr_idx_q + IDX_W'(1);
            if (clr_idx_q == IDX_W'(W - 1)) begin
                state_d     = RUN;
                init_done_d = 1'b1;
            end
        end
        rsp_valid_d = accept ? 1'b1 : (flush || rsp_ready) ? 1'b0 : rsp_valid_q;
        if (accept) begin
            rsp_instr_d = rd_word;
            rsp_fault_d = {req_oor, req_mis};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= CLEAR;
            clr_idx_q   <= '0;
            init_done_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_instr_q <= '0;
            rsp_fault_q <= '0;
        end else begin
            state_q     <= state_d;
            clr_idx_q   <= clr_idx_d;
            init_done_q <= init_done_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_instr_q <= rsp_instr_d;
            rsp_fault_q <= rsp_fault_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_widx] <= mem_wdata;
    end

    assign init_done = init_done_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_instr = rsp_instr_q;
    assign rsp_fault = rsp_fault_q;
endmodule

// File: doc/imem_fetch_unit.md
Name: imem_fetch_unit

Overview:
- Parametrised successor to the fixed byte-cell instruction memory.
- Word-addressable, big-endian instruction store built from CELL_W-bit cells.
- Has a load port for bootloader/bench program download and a valid/ready fetch port with registered response, flush and fault reporting.
- Sits between the IF-stage PC register and the IF/ID pipeline register.
- A hardware clear sequence after reset replaces the old combinational reset-time initialisation.

Parameters:
- WORD_LEN, 32: instruction/load data width in bits.
- CELL_W, 8: addressable cell width in bits. WORD_LEN must be an integer multiple of CELL_W; CELLS = WORD_LEN/CELL_W.
- DEPTH_BYTES, 1024: memory size in cells. Must be a multiple of CELLS.
- ADDR_W, 32: byte (cell) address width.

Ports:
- clk, in, 1: clock, rising edge.
- rst, in, 1: reset, synchronous, active-high.
- ld_en, in, 1: write one word this cycle.
- ld_addr, in, ADDR_W: cell address of the word to write. Must be word-aligned; unaligned or out-of-range loads are dropped.
- ld_data, in, WORD_LEN: word to write. MSB cell goes to ld_addr.
- init_done, out, 1: clear sequence finished.
- req_valid, in, 1: fetch request.
- req_ready, out, 1: fetch request accepted when high together with req_valid.
- req_addr, in, ADDR_W: fetch cell address (PC).
- flush, in, 1: discard the pending response and block new accepts this cycle.
- rsp_valid, out, 1: response available.
- rsp_ready, in, 1: consumer takes the response.
- rsp_instr, out, WORD_LEN: fetched instruction, big-endian concatenation of CELLS cells.
- rsp_fault, out, 2: bit0 = misaligned, bit1 = out of range.

Behaviour:
- Storage: DEPTH_BYTES/CELLS words, word index = addr >> log2(CELLS).
- Address checks:
  - Misaligned: addr[log2(CELLS)-1:0] != 0.
  - Out of range: addr >= DEPTH_BYTES. All ADDR_W bits are compared; there is no truncation or wrap.
- FSM states: CLEAR, RUN.
- Reset (rst=1 at a clock edge):
  - state <= CLEAR, clear index <= 0.
  - rsp_valid <= 0, rsp_instr <= 0, rsp_fault <= 0, init_done <= 0.
  - Reset asserted mid-CLEAR or mid-RUN restarts the clear from index 0. Memory contents are not otherwise defined during reset.
- CLEAR state:
  - Writes 0 (NOP) to one word per cycle, index 0..W-1, where W = DEPTH_BYTES/CELLS.
  - req_ready = 0; ld_en is ignored.
  - After the write of index W-1: state <= RUN and init_done <= 1 on the same edge. CLEAR therefore takes exactly W cycles after rst deasserts.
- RUN state, load port:
  - ld_en with a valid address writes the word at the clock edge.
  - Loads are independent of the fetch handshake.
- RUN state, fetch handshake:
  - req_ready = (state==RUN) && !flush && (!rsp_valid || rsp_ready).
  - Accept = req_valid && req_ready.
  - On accept: the next edge sets rsp_valid = 1, rsp_instr = stored word, rsp_fault = {oor, mis}. Latency is 1 cycle.
  - Faulting fetch: rsp_instr = 0 and the array is not read.
  - While rsp_valid && !rsp_ready: rsp_instr and rsp_fault hold stable and no new request is accepted.
  - rsp_valid && rsp_ready with no accept: rsp_valid <= 0 next edge.
  - rsp_ready && new accept in the same cycle: back-to-back issue, one fetch per cycle.
  - flush=1: rsp_valid <= 0 next edge regardless of rsp_ready. No request is accepted that cycle. rsp_instr and rsp_fault keep their old values.
- Same-cycle load and fetch to the same word: the response returns the OLD word (read-before-write), unless the macro below is defined.
- rsp_instr is read-only once rsp_valid is set: a later load to that word does not change a pending response.

Optional Feature:
- Macro: IMEM_LD_BYPASS_EN.
- Defined: a same-cycle valid load to the word being fetched forwards ld_data into rsp_instr, i.e. the NEW word is returned. Used for self-modifying-code and bootloader streaming.
- Undefined: read-before-write as specified in Behaviour; no forwarding logic is instantiated.

Test Plan:
- Reset, then idle with defaults (W=256): init_done=0 and req_ready=0 for 256 cycles after rst falls, 1 on cycle 256. A fetch at 0x0 then returns 0x00000000 with fault 0.
- Load 0x8020000A@0x0 and 0x04400800@0x4, then back-to-back fetch 0x0, 0x4 with rsp_ready=1: responses 0x8020000A then 0x04400800 on consecutive cycles, one cycle after each accept.
- Fetch 0x2 -> rsp_fault=2'b01, rsp_instr=0. Fetch 0x400 -> rsp_fault=2'b10, rsp_instr=0. Load to 0x400 -> memory unchanged (fetch 0x3FC still old value).
- Hold rsp_ready=0 for 3 cycles with req_valid=1: req_ready=0 and rsp_instr stable for all 3 cycles. Then flush=1 -> rsp_valid=0 next cycle, no accept during the flush cycle.
- Word 0x10 holds 0x11111111; same cycle ld 0x22222222@0x10 and fetch 0x10: response 0x11111111 without IMEM_LD_BYPASS_EN, 0x22222222 with it. A subsequent fetch returns 0x22222222 in both builds.
- rst pulsed at clear index 100, and separately during a pending response: rsp_valid=0 next edge, full W-cycle clear restarts, previously loaded words read 0.
